// File: rtl/aidc_lite_pkg.sv
// aidc_lite_pkg: ZRLE block format shared by the AIDC-Lite compressor and decompressor.
// A compressed block is one header word of eight descriptors followed by literal words.
package aidc_lite_pkg;

    localparam int DESC_W          = 8;
    localparam int FIELD_W         = 4;
    localparam int ZRUN_LSB        = 4;
    localparam int LCNT_LSB        = 0;
    localparam int NUM_DESC        = 8;
    localparam int ZRLE_IBUF_DEPTH = 8;
    localparam int ZRLE_OBLK_WORDS = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_DECODE,
        ST_FIN
    } zrle_state_t;

    typedef struct packed {
        logic [FIELD_W-1:0] zrun;
        logic [FIELD_W-1:0] lcnt;
    } zrle_desc_t;

    // Pull descriptor k out of a header word.
    function automatic zrle_desc_t desc_at(input logic [NUM_DESC*DESC_W-1:0] hdr,
                                           input logic [2:0] k);
        zrle_desc_t        d;
        logic [DESC_W-1:0] b;
        b      = hdr[k*DESC_W +: DESC_W];
        d.zrun = b[ZRUN_LSB +: FIELD_W];
        d.lcnt = b[LCNT_LSB +: FIELD_W];
        return d;
    endfunction

endpackage

// File: rtl/aidc_lite_decomp_zrle.sv
// aidc_lite_decomp_zrle: zero-run-length decompressor for one 128B block.
// Buffers the compressed words, then walks the header descriptors emitting one
// output word per cycle (zeros or literals) addressed into the 16-entry decomp buffer.
module aidc_lite_decomp_zrle #(
    parameter int DATA_W     = 64,
    parameter int IBUF_DEPTH = aidc_lite_pkg::ZRLE_IBUF_DEPTH,
    parameter int OBLK_WORDS = aidc_lite_pkg::ZRLE_OBLK_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic              sop_i,
    input  logic              eop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [3:0]        addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              done_o,
    output logic              fail_o
);
    import aidc_lite_pkg::*;

    zrle_state_t       state;
    logic [DATA_W-1:0] ibuf [IBUF_DEPTH];
    logic [3:0]        wcnt;
    logic [3:0]        lptr;
    logic [3:0]        optr;
    logic [3:0]        zrem;
    logic [3:0]        lrem;
    logic [3:0]        kidx;
    logic              ovf;

    logic              start_blk;
    logic              last_write;
    zrle_desc_t        cur_desc;

    // A sop restarts the block from IDLE or from the middle of a reception.
    assign start_blk  = valid_i && sop_i && (state == ST_IDLE || state == ST_RECV);
    assign last_write = (optr == 4'(OBLK_WORDS - 1));
    assign cur_desc   = desc_at(ibuf[0], kidx[2:0]);

    // Block FSM: receive words, decode one output per cycle, report done/fail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            wcnt    <= '0;
            lptr    <= '0;
            optr    <= '0;
            zrem    <= '0;
            lrem    <= '0;
            kidx    <= '0;
            ovf     <= 1'b0;
            valid_o <= 1'b0;
            addr_o  <= '0;
            data_o  <= '0;
            done_o  <= 1'b0;
            fail_o  <= 1'b0;
            for (int i = 0; i < IBUF_DEPTH; i++) begin
                ibuf[i] <= '0;
            end
        end else begin
            valid_o <= 1'b0;
            if (start_blk) begin
                ibuf[0] <= data_i;
                wcnt    <= 4'd1;
                lptr    <= 4'd1;
                optr    <= '0;
                zrem    <= '0;
                lrem    <= '0;
                kidx    <= '0;
                ovf     <= 1'b0;
                done_o  <= 1'b0;
                fail_o  <= 1'b0;
                state   <= eop_i ? ST_DECODE : ST_RECV;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end
                    ST_RECV: begin
                        if (valid_i) begin
                            if (wcnt == 4'(IBUF_DEPTH)) begin
                                ovf <= 1'b1;
                            end else begin
                                ibuf[wcnt[2:0]] <= data_i;
                                wcnt            <= wcnt + 4'd1;
                            end
                            if (eop_i) begin
                                state <= ST_DECODE;
                            end
                        end
                    end
                    ST_DECODE: begin
                        if (ovf) begin
                            done_o <= 1'b1;
                            fail_o <= 1'b1;
                            state  <= ST_IDLE;
                        end else if (zrem != 4'd0) begin
                            zrem    <= zrem - 4'd1;
                            valid_o <= 1'b1;
                            addr_o  <= optr;
                            data_o  <= '0;
                            optr    <= optr + 4'd1;
                            if (last_write) begin
                                state <= ST_FIN;
                            end
                        end else if (lrem != 4'd0) begin
                            if (lptr == wcnt) begin
                                done_o <= 1'b1;
                                fail_o <= 1'b1;
                                state  <= ST_IDLE;
                            end else begin
                                lrem    <= lrem - 4'd1;
                                lptr    <= lptr + 4'd1;
                                valid_o <= 1'b1;
                                addr_o  <= optr;
                                data_o  <= ibuf[lptr[2:0]];
                                optr    <= optr + 4'd1;
                                if (last_write) begin
                                    state <= ST_FIN;
                                end
                            end
                        end else if (kidx == 4'(NUM_DESC)) begin
                            done_o <= 1'b1;
                            fail_o <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            zrem <= cur_desc.zrun;
                            lrem <= cur_desc.lcnt;
                            kidx <= kidx + 4'd1;
                        end
                    end
                    ST_FIN: begin
                        done_o <= 1'b1;
                        fail_o <= (lptr != wcnt);
                        state  <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aidc_lite_decomp_zrle.sv
// tb_aidc_lite_decomp_zrle: directed table, hand sequences and random packets
// for the ZRLE decompressor, checked against a descriptor-walking reference model.
module tb_aidc_lite_decomp_zrle;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        sop_i = 1'b0;
    logic        eop_i = 1'b0;
    logic [63:0] data_i = '0;
    logic        valid_o;
    logic [3:0]  addr_o;
    logic [63:0] data_o;
    logic        done_o;
    logic        fail_o;

    aidc_lite_decomp_zrle dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .sop_i   (sop_i),
        .eop_i   (eop_i),
        .data_i  (data_i),
        .valid_o (valid_o),
        .addr_o  (addr_o),
        .data_o  (data_o),
        .done_o  (done_o),
        .fail_o  (fail_o)
    );

    always #5 clk = ~clk;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    logic [63:0] pkt [$];
    logic [3:0]  wr_addr [$];
    logic [63:0] wr_data [$];
    int          last_wr_cyc = 0;
    bit          collect = 1'b0;
    logic [63:0] exp_data [16];
    int          exp_nwr;
    bit          exp_fail;

    localparam logic [63:0] LIT_A = 64'hAAAA_0000_1111_000A;
    localparam logic [63:0] LIT_B = 64'hBBBB_2222_3333_000B;
    localparam logic [63:0] LIT_C = 64'hCCCC_4444_5555_000C;

    typedef struct {
        string       name;
        logic [63:0] hdr;
        int          nlit;
        logic [63:0] lits [8];
        int          want_nwr;
        bit          want_fail;
        int          want_lat;
    } vec_t;

    vec_t vecs [7];

    // Free-running cycle count used to measure latencies.
    always @(posedge clk) cyc++;

    // Capture every output buffer write while a block is being checked.
    always @(negedge clk) begin
        if (collect && valid_o) begin
            wr_addr.push_back(addr_o);
            wr_data.push_back(data_o);
            last_wr_cyc = cyc;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expected outcome of the packet in pkt, straight from the format rules.
    function automatic void ref_model();
        int          lit;
        int          zr;
        int          lc;
        logic [63:0] hdr;
        exp_nwr  = 0;
        exp_fail = 1'b0;
        lit      = 1;
        for (int i = 0; i < 16; i++) exp_data[i] = '0;
        if (pkt.size() > 8) begin
            exp_fail = 1'b1;
            return;
        end
        hdr = pkt[0];
        for (int k = 0; k < 8 && exp_nwr < 16; k++) begin
            zr = int'((hdr >> (8 * k + 4)) & 64'hF);
            lc = int'((hdr >> (8 * k)) & 64'hF);
            for (int z = 0; z < zr && exp_nwr < 16; z++) begin
                exp_data[exp_nwr] = '0;
                exp_nwr++;
            end
            for (int l = 0; l < lc && exp_nwr < 16; l++) begin
                if (lit >= pkt.size()) begin
                    exp_fail = 1'b1;
                    return;
                end
                exp_data[exp_nwr] = pkt[lit];
                exp_nwr++;
                lit++;
            end
        end
        if (exp_nwr < 16) exp_fail = 1'b1;
        else if (lit != pkt.size()) exp_fail = 1'b1;
    endfunction

    task automatic applyStimulus(output int eop_cyc);
        for (int i = 0; i < pkt.size(); i++) begin
            valid_i = 1'b1;
            sop_i   = (i == 0);
            eop_i   = (i == pkt.size() - 1);
            data_i  = pkt[i];
            @(posedge clk);
            #1;
        end
        eop_cyc = cyc;
        valid_i = 1'b0;
        sop_i   = 1'b0;
        eop_i   = 1'b0;
        data_i  = '0;
    endtask

    task automatic run_block(input string tag, input int want_nwr, input bit want_fail, input int want_lat);
        int eop_cyc;
        int done_cyc;
        bit seen;
        ref_model();
        wr_addr.delete();
        wr_data.delete();
        collect = 1'b1;
        applyStimulus(eop_cyc);
        checkOutput({tag, " done cleared by sop"}, 64'(done_o), 64'd0);
        seen     = 1'b0;
        done_cyc = 0;
        for (int w = 0; w < 80 && !seen; w++) begin
            @(negedge clk);
            if (done_o) begin
                seen     = 1'b1;
                done_cyc = cyc;
            end
        end
        collect = 1'b0;
        checkOutput({tag, " done seen"}, 64'(seen), 64'd1);
        checkOutput({tag, " fail_o"}, 64'(fail_o), 64'(want_fail));
        checkOutput({tag, " write count"}, 64'(wr_addr.size()), 64'(want_nwr));
        for (int i = 0; i < wr_addr.size() && i < 16; i++) begin
            checkOutput($sformatf("%s addr[%0d]", tag, i), 64'(wr_addr[i]), 64'(i));
            checkOutput($sformatf("%s data[%0d]", tag, i), wr_data[i], exp_data[i]);
        end
        if (want_nwr == 16 && seen)
            checkOutput({tag, " done after last write"}, 64'(done_cyc - last_wr_cyc), 64'd1);
        if (want_lat > 0 && seen)
            checkOutput({tag, " done latency"}, 64'(done_cyc - eop_cyc), 64'(want_lat));
    endtask

    task automatic load_vec(input int v);
        pkt.delete();
        pkt.push_back(vecs[v].hdr);
        for (int i = 0; i < vecs[v].nlit; i++) pkt.push_back(vecs[v].lits[i]);
    endtask

    initial begin
        int          dummy;
        int          remain;
        int          litsum;
        int          zr;
        int          lc;
        int          ml;
        int          nl;
        logic [63:0] hdr;

        vecs[0] = '{name: "all-zero", hdr: 64'h10F0, nlit: 0, lits: '{default: '0},
                    want_nwr: 16, want_fail: 1'b0, want_lat: 0};
        vecs[1] = '{name: "mixed", hdr: 64'hB023, nlit: 3,
                    lits: '{LIT_A, LIT_B, LIT_C, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0},
                    want_nwr: 16, want_fail: 1'b0, want_lat: 0};
        vecs[2] = '{name: "overrun", hdr: 64'h00F2, nlit: 2,
                    lits: '{LIT_A, LIT_B, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0},
                    want_nwr: 16, want_fail: 1'b1, want_lat: 0};
        vecs[3] = '{name: "short", hdr: 64'h9007, nlit: 5,
                    lits: '{64'h11, 64'h22, 64'h33, 64'h44, 64'h55, 64'h0, 64'h0, 64'h0},
                    want_nwr: 5, want_fail: 1'b1, want_lat: 0};
        vecs[4] = '{name: "oversize", hdr: 64'h10F0, nlit: 8,
                    lits: '{64'h1, 64'h2, 64'h3, 64'h4, 64'h5, 64'h6, 64'h7, 64'h8},
                    want_nwr: 0, want_fail: 1'b1, want_lat: 1};
        vecs[5] = '{name: "full8", hdr: 64'h9007, nlit: 7,
                    lits: '{64'h71, 64'h72, 64'h73, 64'h74, 64'h75, 64'h76, 64'h77, 64'h0},
                    want_nwr: 16, want_fail: 1'b0, want_lat: 0};
        vecs[6] = '{name: "desc-exhaust", hdr: 64'h11, nlit: 1,
                    lits: '{LIT_C, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0},
                    want_nwr: 2, want_fail: 1'b1, want_lat: 0};

        repeat (3) @(negedge clk);
        checkOutput("reset valid_o", 64'(valid_o), 64'd0);
        checkOutput("reset addr_o", 64'(addr_o), 64'd0);
        checkOutput("reset data_o", data_o, 64'd0);
        checkOutput("reset done_o", 64'(done_o), 64'd0);
        checkOutput("reset fail_o", 64'(fail_o), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) begin
            load_vec(v);
            run_block(vecs[v].name, vecs[v].want_nwr, vecs[v].want_fail, vecs[v].want_lat);
        end

        load_vec(1);
        run_block("mixed-hold", 16, 1'b0, 0);
        repeat (3) @(negedge clk);
        checkOutput("done held", 64'(done_o), 64'd1);
        wr_addr.delete();
        collect = 1'b1;
        valid_i = 1'b1;
        data_i  = 64'hDEAD;
        @(negedge clk);
        valid_i = 1'b0;
        data_i  = '0;
        repeat (3) @(negedge clk);
        collect = 1'b0;
        checkOutput("stray word no write", 64'(wr_addr.size()), 64'd0);
        checkOutput("stray word done held", 64'(done_o), 64'd1);
        checkOutput("stray word fail held", 64'(fail_o), 64'd0);

        load_vec(1);
        applyStimulus(dummy);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset valid_o", 64'(valid_o), 64'd0);
        checkOutput("midreset addr_o", 64'(addr_o), 64'd0);
        checkOutput("midreset data_o", data_o, 64'd0);
        checkOutput("midreset done_o", 64'(done_o), 64'd0);
        checkOutput("midreset fail_o", 64'(fail_o), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_vec(1);
        run_block("after-reset", 16, 1'b0, 0);

        for (int r = 0; r < 40; r++) begin
            hdr    = '0;
            remain = 16;
            litsum = 0;
            if ($urandom_range(3, 0) == 0) begin
                hdr = {$urandom, $urandom};
                nl  = int'($urandom_range(8, 0));
            end else begin
                for (int k = 0; k < 8; k++) begin
                    zr = (k == 7) ? ((remain > 15) ? 15 : remain)
                                  : int'($urandom_range(((remain > 15) ? 15 : remain), 0));
                    remain -= zr;
                    ml = 7 - litsum;
                    if (ml > remain) ml = remain;
                    lc = int'($urandom_range(ml, 0));
                    remain -= lc;
                    litsum += lc;
                    hdr = hdr | (64'(zr * 16 + lc) << (8 * k));
                end
                nl = litsum;
                if ($urandom_range(4, 0) == 0) nl = litsum + 1;
                else if ($urandom_range(4, 0) == 0 && litsum > 0) nl = litsum - 1;
            end
            pkt.delete();
            pkt.push_back(hdr);
            for (int i = 0; i < nl; i++) pkt.push_back({$urandom, $urandom});
            ref_model();
            run_block($sformatf("rand%0d", r), exp_nwr, exp_fail, 0);
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
